// File: rtl/store_queue.sv
// In-order store queue: converts sb/sh/sw/sd requests into doubleword-aligned byte-masked
// writes, drains them over a valid/ready write port and flags loads that hit a pending store.
module store_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [63:0]              st_addr,
    input  logic [63:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     st_misalign,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [63:0]              mem_waddr,
    output logic [63:0]              mem_wdata,
    output logic [7:0]               mem_wmask,
    input  logic [63:0]              ld_chk_addr,
    output logic                     ld_hazard,
    output logic                     sq_empty,
    output logic [$clog2(DEPTH):0]   sq_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // Handshakes: a store transfers on st_valid && st_ready, a write on mem_wvalid && mem_wready,
    // both at the rising edge; the write port holds its payload until it transfers.
    logic [60:0]   r_addr [DEPTH];
    logic [63:0]   r_data [DEPTH];
    logic [7:0]    r_mask [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_misalign;

    logic          w_mis;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_mask_base;
    logic [7:0]    w_lane_mask;
    logic [63:0]   w_lane_data;
    logic          w_hazard;
    logic [PW-1:0] w_rel;

    always_comb begin
        w_mis       = 1'b0;
        w_mask_base = 8'h01;
        case (st_size)
            2'd0: begin w_mis = 1'b0;           w_mask_base = 8'h01; end
            2'd1: begin w_mis = st_addr[0];     w_mask_base = 8'h03; end
            2'd2: begin w_mis = |st_addr[1:0];  w_mask_base = 8'h0F; end
            default: begin w_mis = |st_addr[2:0]; w_mask_base = 8'hFF; end
        endcase
    end

    assign w_lane_mask = w_mask_base << st_addr[2:0];
    assign w_lane_data = st_data << {st_addr[2:0], 3'b000};

    assign st_ready = (r_count < FULL_CNT);
    assign w_push   = st_valid && st_ready && !w_mis;
    assign w_pop    = mem_wvalid && mem_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= st_valid && st_ready && w_mis;
            if (w_push) r_tail <= r_tail + PTR_ONE;
            if (w_pop)  r_head <= r_head + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr[63:3];
            r_data[r_tail] <= w_lane_data;
            r_mask[r_tail] <= w_lane_mask;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        w_hazard = 1'b0;
        w_rel    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rel = PW'(i) - r_head;
            if (({1'b0, w_rel} < r_count) && (r_addr[i] == ld_chk_addr[63:3]))
                w_hazard = 1'b1;
        end
    end

    assign sq_count    = r_count;
    assign sq_empty    = (r_count == '0);
    assign mem_wvalid  = !sq_empty;
    assign st_misalign = r_misalign;
    assign ld_hazard   = w_hazard;
    assign mem_waddr   = mem_wvalid ? {r_addr[r_head], 3'b000} : 64'h0;
    assign mem_wdata   = mem_wvalid ? r_data[r_head] : 64'h0;
    assign mem_wmask   = mem_wvalid ? r_mask[r_head] : 8'h0;

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: table of single-store vectors, then hand-written sequences for
// backpressure/full, pointer wrap, load hazard, misalignment with entries pending and async reset.
module tb_store_queue;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        st_misalign;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] ld_chk_addr;
  logic        ld_hazard;
  logic        sq_empty;
  logic [$clog2(DEPTH):0] sq_count;

  store_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_misalign(st_misalign),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .ld_chk_addr(ld_chk_addr), .ld_hazard(ld_hazard),
    .sq_empty(sq_empty), .sq_count(sq_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // independent byte-wise reference of one write: {waddr, wdata, wmask}
  function automatic logic [135:0] model(input logic [63:0] addr, input logic [63:0] data,
                                         input logic [1:0] size);
    logic [63:0] d;
    logic [7:0]  m;
    int off;
    int n;
    d = '0;
    m = '0;
    off = int'(addr[2:0]);
    n = 1 << size;
    for (int b = 0; b < 8; b++) begin
      if (b >= off) d[8*b +: 8] = data[8*(b-off) +: 8];
      if (b >= off && b < off + n) m[b] = 1'b1;
    end
    return {addr[63:3], 3'b000, d, m};
  endfunction

  // driver tasks
  task automatic drive_store(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
    st_valid = 1'b1;
    st_addr  = addr;
    st_data  = data;
    st_size  = size;
  endtask

  task automatic idle();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (!sq_empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {63'h0, sq_empty}, 64'h1);
  endtask

  // scoreboard: every transferred write is compared against the expected queue
  logic [135:0] exp_q[$];
  logic         sb_en = 1'b0;

  always @(negedge clk) begin
    logic [135:0] e;
    #2;
    if (sb_en && rst_n && mem_wvalid && mem_wready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got addr %h data %h mask %h expected no write",
                 mem_waddr, mem_wdata, mem_wmask);
      end else begin
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata, mem_wmask} !== e) begin
          errors++;
          $display("FAIL sb_write: got %h/%h/%h expected %h/%h/%h",
                   mem_waddr, mem_wdata, mem_wmask, e[135:72], e[71:8], e[7:0]);
        end
      end
    end
  end

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic        mis;
    logic [63:0] e_addr;
    logic [63:0] e_data;
    logic [7:0]  e_mask;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{64'h8000_0005, 64'hAB,                  2'd0, 1'b0, 64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20};
    vecs[1] = '{64'h8000_0006, 64'h1122_3344_5566_7788, 2'd1, 1'b0, 64'h8000_0000, 64'h7788_0000_0000_0000, 8'hC0};
    vecs[2] = '{64'h8000_0004, 64'h1122_3344_5566_7788, 2'd2, 1'b0, 64'h8000_0000, 64'h5566_7788_0000_0000, 8'hF0};
    vecs[3] = '{64'h8000_0000, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF};
    vecs[4] = '{64'h8000_0017, 64'h1234_5678_9ABC_DEF0, 2'd0, 1'b0, 64'h8000_0010, 64'hF000_0000_0000_0000, 8'h80};
    vecs[5] = '{64'h8000_0002, 64'hDEAD_BEEF,           2'd2, 1'b1, 64'h0,         64'h0,                   8'h00};
    vecs[6] = '{64'h8000_0004, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b1, 64'h0,         64'h0,                   8'h00};
    vecs[7] = '{64'h8000_0001, 64'hBEEF,                2'd1, 1'b1, 64'h0,         64'h0,                   8'h00};
    vecs[8] = '{64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01};
    vecs[9] = '{64'h8000_002A, 64'hBEEF,                2'd1, 1'b0, 64'h8000_0028, 64'h0000_BEEF_0000,      8'h0C};

    rst_n = 1'b0;
    st_valid = 1'b0;
    st_addr = '0;
    st_data = '0;
    st_size = '0;
    mem_wready = 1'b0;
    ld_chk_addr = '0;

    // reset state
    @(negedge clk);
    chk("rst_count", 64'(sq_count), 64'h0);
    chk("rst_empty", 64'(sq_empty), 64'h1);
    chk("rst_ready", 64'(st_ready), 64'h1);
    chk("rst_wvalid", 64'(mem_wvalid), 64'h0);
    chk("rst_waddr", mem_waddr, 64'h0);
    chk("rst_wdata", mem_wdata, 64'h0);
    chk("rst_wmask", 64'(mem_wmask), 64'h0);
    chk("rst_misalign", 64'(st_misalign), 64'h0);
    chk("rst_hazard", 64'(ld_hazard), 64'h0);
    rst_n = 1'b1;
    mem_wready = 1'b1;
    @(negedge clk);

    // table-driven single stores, drained immediately
    for (int i = 0; i < 10; i++) begin
      drive_store(vecs[i].addr, vecs[i].data, vecs[i].size);
      @(posedge clk);
      @(negedge clk);
      idle();
      if (!vecs[i].mis) begin
        chk($sformatf("v%0d_wvalid", i), 64'(mem_wvalid), 64'h1);
        chk($sformatf("v%0d_waddr", i), mem_waddr, vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_data);
        chk($sformatf("v%0d_wmask", i), 64'(mem_wmask), 64'(vecs[i].e_mask));
        chk($sformatf("v%0d_nomis", i), 64'(st_misalign), 64'h0);
      end else begin
        chk($sformatf("v%0d_misalign", i), 64'(st_misalign), 64'h1);
        chk($sformatf("v%0d_wvalid", i), 64'(mem_wvalid), 64'h0);
        chk($sformatf("v%0d_count", i), 64'(sq_count), 64'h0);
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_mis_clear", i), 64'(st_misalign), 64'h0);
      chk($sformatf("v%0d_empty", i), 64'(sq_empty), 64'h1);
    end

    // fill to full under backpressure, then a pop while a push is attempted
    sb_en = 1'b1;
    mem_wready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      drive_store(64'h2000 + 64'(8*k), 64'hA0A0_0000_0000_0000 | 64'(k), 2'd3);
      exp_q.push_back(model(64'h2000 + 64'(8*k), 64'hA0A0_0000_0000_0000 | 64'(k), 2'd3));
      @(negedge clk);
    end
    drive_store(64'h3000, 64'h3333, 2'd3);
    chk("full_ready", 64'(st_ready), 64'h0);
    chk("full_count", 64'(sq_count), 64'(DEPTH));
    chk("full_head_addr", mem_waddr, 64'h2000);
    @(negedge clk);
    chk("full_hold_count", 64'(sq_count), 64'(DEPTH));
    chk("full_hold_addr", mem_waddr, 64'h2000);
    chk("full_hold_data", mem_wdata, 64'hA0A0_0000_0000_0000);
    mem_wready = 1'b1;
    @(negedge clk);
    idle();
    mem_wready = 1'b0;
    chk("pop_no_pass_count", 64'(sq_count), 64'(DEPTH-1));
    chk("pop_ready", 64'(st_ready), 64'h1);
    chk("pop_next_head", mem_waddr, 64'h2008);
    mem_wready = 1'b1;
    wait_empty("full_drain", 20);

    // streaming over 3*DEPTH stores to wrap the pointers
    for (int k = 0; k < 3*DEPTH; k++) begin
      logic [1:0]  sz;
      logic [63:0] a;
      logic [63:0] d;
      int off;
      sz  = 2'(k % 4);
      off = ((k * 5) % 8) & ~((1 << sz) - 1);
      a   = 64'h4000 + 64'(8*k) + 64'(off);
      d   = {$urandom(), $urandom()};
      chk($sformatf("wrap%0d_ready", k), 64'(st_ready), 64'h1);
      drive_store(a, d, sz);
      exp_q.push_back(model(a, d, sz));
      @(negedge clk);
    end
    idle();
    wait_empty("wrap_drain", 20);
    chk("wrap_sb_left", 64'(exp_q.size()), 64'h0);

    // load hazard, plus a misaligned store while an entry is pending
    mem_wready = 1'b0;
    drive_store(64'h1008, 64'h5555_6666_7777_8888, 2'd3);
    exp_q.push_back(model(64'h1008, 64'h5555_6666_7777_8888, 2'd3));
    ld_chk_addr = 64'h1008;
    #1;
    chk("haz_same_cycle", 64'(ld_hazard), 64'h0);
    @(negedge clk);
    idle();
    ld_chk_addr = 64'h100C;
    #1;
    chk("haz_hit", 64'(ld_hazard), 64'h1);
    ld_chk_addr = 64'h1010;
    #1;
    chk("haz_miss", 64'(ld_hazard), 64'h0);
    drive_store(64'h1002, 64'h1234, 2'd2);
    @(negedge clk);
    idle();
    chk("mis_pend_flag", 64'(st_misalign), 64'h1);
    chk("mis_pend_count", 64'(sq_count), 64'h1);
    @(negedge clk);
    chk("mis_pend_clear", 64'(st_misalign), 64'h0);
    mem_wready = 1'b1;
    @(negedge clk);
    mem_wready = 1'b0;
    ld_chk_addr = 64'h100C;
    #1;
    chk("haz_after_pop", 64'(ld_hazard), 64'h0);
    chk("haz_after_pop_empty", 64'(sq_empty), 64'h1);
    @(negedge clk);

    // asynchronous reset with three writes pending
    for (int k = 0; k < 3; k++) begin
      drive_store(64'h5000 + 64'(8*k), 64'(k + 1), 2'd3);
      @(negedge clk);
    end
    idle();
    chk("prerst_wvalid", 64'(mem_wvalid), 64'h1);
    chk("prerst_count", 64'(sq_count), 64'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wvalid", 64'(mem_wvalid), 64'h0);
    chk("async_rst_count", 64'(sq_count), 64'h0);
    chk("async_rst_empty", 64'(sq_empty), 64'h1);
    chk("async_rst_wmask", 64'(mem_wmask), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_wready = 1'b1;
    drive_store(64'h6003, 64'h5A, 2'd0);
    exp_q.push_back(model(64'h6003, 64'h5A, 2'd0));
    @(negedge clk);
    idle();
    chk("postrst_wvalid", 64'(mem_wvalid), 64'h1);
    chk("postrst_waddr", mem_waddr, 64'h6000);
    chk("postrst_wmask", 64'(mem_wmask), 64'h08);
    @(negedge clk);
    chk("postrst_empty", 64'(sq_empty), 64'h1);
    chk("final_sb_left", 64'(exp_q.size()), 64'h0);
    sb_en = 1'b0;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_queue.md
# store_queue

Write-side counterpart of the load path: buffers store instructions (sb/sh/sw/sd) from execute, converts each to an 8-byte-aligned, lane-shifted, byte-masked memory write, and drains them in order to the data memory port through a valid/ready handshake. It sits between the execute stage and the data memory write port. It flags loads that hit a pending store so the pipeline can stall until the store drains.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- st_valid  in  1  store request present
- st_ready  out  1  queue can accept a store (= not full)
- st_addr  in  64  effective byte address (base + offset, already summed)
- st_data  in  64  store data, right-aligned (rs2)
- st_size  in  2  0=byte, 1=half, 2=word, 3=dword
- st_misalign  out  1  one-cycle pulse: last accepted request was misaligned and dropped
- mem_wvalid  out  1  head entry valid on write port
- mem_wready  in  1  memory accepts write this cycle
- mem_waddr  out  64  {st_addr[63:3], 3'b000}
- mem_wdata  out  64  lane-shifted data
- mem_wmask  out  8  byte enables
- ld_chk_addr  in  64  load address being checked
- ld_hazard  out  1  a stored entry targets the same doubleword as ld_chk_addr
- sq_empty  out  1  no entries held
- sq_count  out  log2(DEPTH)+1  entries held

## Operation
- Handshake accept: st_valid && st_ready at a rising edge.
- Alignment check on accept: misaligned if (size 1 && addr[0]) || (size 2 && addr[1:0]≠0) || (size 3 && addr[2:0]≠0). Misaligned request is consumed (not retried) but not enqueued; st_misalign=1 for the following cycle only.
- Aligned accept writes tail entry: waddr = addr & ~7; off = addr[2:0]; wdata = st_data << (8·off), truncated to 64 bits; wmask = ((1<<(1<<size))−1) << off, truncated to 8 bits. Byte at off 7 → mask 8'h80; dword → 8'hFF.
- Drain: mem_wvalid = !sq_empty; mem_w* driven from head entry registers. Head pops on mem_wvalid && mem_wready. mem_waddr/wdata/wmask stay stable while mem_wvalid=1 and mem_wready=0.
- Strict FIFO order; no merging, no reordering.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; sq_count disambiguates full vs empty.
- st_ready = (sq_count < DEPTH). No pass-through when full: a push while full is impossible even if a pop occurs that cycle.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- ld_hazard: OR over valid stored entries of (entry.waddr[63:3] == ld_chk_addr[63:3]); combinational; includes the head even while its write is in flight; excludes a store being accepted in the same cycle (execute stalls loads one cycle behind a store to the same doubleword).
- No flush input: accepted stores always complete.

## Timing
- Reset (asserted, async): sq_count=0, sq_empty=1, st_ready=1, mem_wvalid=0, mem_waddr/wdata/wmask=0, st_misalign=0, ld_hazard=0, pointers=0. Reset mid-drain discards all entries; mem_wvalid falls immediately, not at next edge.
- Enqueue-to-mem_wvalid latency: 1 cycle (store accepted at edge N is visible on mem_w* after edge N when queue was empty).
- Throughput: 1 store/cycle in, 1 write/cycle out with mem_wready held high.
- st_misalign asserts after the accepting edge, deasserts after the next edge unless another misaligned accept occurs.
- sq_count, sq_empty, st_ready are registered-state functions; they update after the edge.

## Test plan
- Reset then sb addr=0x8000_0005 data=0xAB, mem_wready=1 → next cycle mem_wvalid=1, waddr=0x8000_0000, wdata=0x0000_AB00_0000_0000, wmask=8'h20; popped at that edge, sq_empty=1 after.
- sh/sw/sd at 0x...06/0x...04/0x...00 data 0x1122_3344_5566_7788 → masks 8'hC0/8'hF0/8'hFF, wdata 0x7788<<48 / 0x5566_7788<<32 / full value, in order.
- mem_wready=0, push DEPTH aligned stores → st_ready=0, sq_count=DEPTH, head outputs stable; raise mem_wready 1 cycle → one pop, st_ready=1; pointer wrap verified over 3·DEPTH stores with data intact.
- sw addr=0x...02 → not enqueued, st_misalign=1 exactly one cycle, sq_count unchanged; sd addr=0x...04 likewise.
- Store to 0x1008 pending, ld_chk_addr=0x100C → ld_hazard=1; ld_chk_addr=0x1010 → 0; after pop → 0.
- rst_n low while 3 entries pending and mem_wvalid=1 → mem_wvalid=0 asynchronously, sq_count=0; after release, new store drains normally.
